// File: rtl/ups_axi_pkg.sv
// Shared types and helpers for the UPS AXI4-Lite register slave.
// Contents: read/write FSM state enums, AXI response codes, and the
// strobe-masked byte merge function.
package ups_axi_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_DEC,
    RD_RESP
  } rd_state_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_A,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Replace each byte of old_word whose strobe bit is set with the byte of new_word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = new_word[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ups_axi_strb_merge.sv
// Combinational 32-bit byte merge under a 4-bit strobe.
// Ports: old_word (current value), new_word (write data), strb (byte enables),
//        merged (result).
module ups_axi_strb_merge
  import ups_axi_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  assign merged = strb_merge(old_word, new_word, strb);

endmodule

// File: rtl/ups_axi_regs.sv
// AXI4-Lite register slave: NW read/write control registers followed by NS
// status registers in the word address map, with byte strobes, independent
// AW/W acceptance, SLVERR on unmapped words and per-register write pulses.
// Ports: clk, rst (sync, active-high); data (NW x 32 control contents, flat);
//        dv (one-cycle write pulse per control register); status (NS x 32, flat);
//        ca4l_* AXI4-Lite slave channels AR/R/AW/W/B.
// Build option: UPS_AXI_REGS_W1C_EN makes status registers sticky and
// write-one-to-clear; otherwise they are registered read-only pass-through.
module ups_axi_regs
  import ups_axi_pkg::*;
#(
  parameter int unsigned NW = 16,
  parameter int unsigned NS = 4,
  parameter int unsigned AW = 9
) (
  input  logic             clk,
  input  logic             rst,
  output logic [32*NW-1:0] data,
  output logic [NW-1:0]    dv,
  input  logic [32*NS-1:0] status,
  input  logic [31:0]      ca4l_araddr,
  input  logic             ca4l_arvalid,
  output logic             ca4l_arready,
  output logic [31:0]      ca4l_rdata,
  output logic [1:0]       ca4l_rresp,
  output logic             ca4l_rvalid,
  input  logic             ca4l_rready,
  input  logic [31:0]      ca4l_awaddr,
  input  logic             ca4l_awvalid,
  output logic             ca4l_awready,
  input  logic [31:0]      ca4l_wdata,
  input  logic [3:0]       ca4l_wstrb,
  input  logic             ca4l_wvalid,
  output logic             ca4l_wready,
  output logic [1:0]       ca4l_bresp,
  output logic             ca4l_bvalid,
  input  logic             ca4l_bready
);

  localparam int unsigned IW = AW - 2;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

  logic [31:0] data_q [NW];
  logic [31:0] stat_q [NS];
  logic [NW-1:0] dv_q;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ca4l_araddr[31:AW], ca4l_araddr[1:0],
                              ca4l_awaddr[31:AW], ca4l_awaddr[1:0]};

  for (genvar i = 0; i < NW; i++) begin : g_data
    assign data[32*i +: 32] = data_q[i];
  end
  assign dv = dv_q;

  // ---------------- read side ----------------
  rd_state_t   rd_state, rd_next;
  logic        arready_d, rvalid_d;
  logic [IW-1:0] rd_idx;
  logic [31:0] rd_sel;
  logic [1:0]  rd_resp;
  logic        ar_hs;

  assign ar_hs = ca4l_arvalid && ca4l_arready;

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DEC;
      RD_DEC:  rd_next = RD_RESP;
      RD_RESP: if (ca4l_rvalid && ca4l_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
    arready_d = (rd_next == RD_IDLE);
    rvalid_d  = (rd_next == RD_RESP);
  end

  // Read mux: control, status or unmapped.
  always_comb begin
    rd_sel  = '0;
    rd_resp = AXI_RESP_SLVERR;
    if (32'(rd_idx) < NW) begin
      rd_sel  = data_q[CW'(rd_idx)];
      rd_resp = AXI_RESP_OKAY;
    end else if (32'(rd_idx) < NW + NS) begin
      rd_sel  = stat_q[SW'(32'(rd_idx) - NW)];
      rd_resp = AXI_RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= RD_IDLE;
      ca4l_arready <= 1'b0;
      ca4l_rvalid  <= 1'b0;
      ca4l_rdata   <= '0;
      ca4l_rresp   <= '0;
      rd_idx       <= '0;
    end else begin
      rd_state     <= rd_next;
      ca4l_arready <= arready_d;
      ca4l_rvalid  <= rvalid_d;
      if (ar_hs) rd_idx <= ca4l_araddr[AW-1:2];
      // Decoded once; held stable through any rready backpressure.
      if (rd_state == RD_DEC) begin
        ca4l_rdata <= rd_sel;
        ca4l_rresp <= rd_resp;
      end
    end
  end

  // ---------------- write side ----------------
  wr_state_t   wr_state, wr_next;
  logic        awready_d, wready_d, bvalid_d;
  logic        aw_hs, w_hs, commit;
  logic [IW-1:0] wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_is_ctrl;
  logic [1:0]  wr_resp;
  logic [31:0] ctrl_merged;

  assign aw_hs      = ca4l_awvalid && ca4l_awready;
  assign w_hs       = ca4l_wvalid && ca4l_wready;
  assign commit     = (wr_state == WR_COMMIT);
  assign wr_is_ctrl = (32'(wr_idx) < NW);

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_COMMIT;
        else if (aw_hs)    wr_next = WR_HAVE_A;
        else if (w_hs)     wr_next = WR_HAVE_W;
      end
      WR_HAVE_A: if (w_hs)  wr_next = WR_COMMIT;
      WR_HAVE_W: if (aw_hs) wr_next = WR_COMMIT;
      WR_COMMIT: wr_next = WR_RESP;
      WR_RESP:   if (ca4l_bvalid && ca4l_bready) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
    awready_d = (wr_next == WR_IDLE) || (wr_next == WR_HAVE_W);
    wready_d  = (wr_next == WR_IDLE) || (wr_next == WR_HAVE_A);
    bvalid_d  = (wr_next == WR_RESP);
  end

`ifdef UPS_AXI_REGS_W1C_EN
  logic          wr_is_stat;
  logic [SW-1:0] wr_sidx;
  logic [31:0]   clr;
  assign wr_is_stat = !wr_is_ctrl && (32'(wr_idx) < NW + NS);
  assign wr_sidx    = SW'(32'(wr_idx) - NW);

  ups_axi_strb_merge u_clr_merge (
    .old_word (32'h0),
    .new_word (wr_data),
    .strb     (wr_strb),
    .merged   (clr)
  );

  always_comb begin
    wr_resp = AXI_RESP_SLVERR;
    if (wr_is_ctrl || wr_is_stat) wr_resp = AXI_RESP_OKAY;
  end

  // Sticky status: a set arriving in the same cycle as a clear survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (commit && wr_is_stat && (wr_sidx == SW'(i)))
          stat_q[i] <= (stat_q[i] & ~clr) | status[32*i +: 32];
        else
          stat_q[i] <= stat_q[i] | status[32*i +: 32];
      end
    end
  end
`else
  always_comb begin
    wr_resp = AXI_RESP_SLVERR;
    if (wr_is_ctrl) wr_resp = AXI_RESP_OKAY;
  end

  // One-stage registered pass-through of the status inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NS; i++) stat_q[i] <= status[32*i +: 32];
    end
  end
`endif

  ups_axi_strb_merge u_ctrl_merge (
    .old_word (data_q[CW'(wr_idx)]),
    .new_word (wr_data),
    .strb     (wr_strb),
    .merged   (ctrl_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state     <= WR_IDLE;
      ca4l_awready <= 1'b0;
      ca4l_wready  <= 1'b0;
      ca4l_bvalid  <= 1'b0;
      ca4l_bresp   <= '0;
      wr_idx       <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
    end else begin
      wr_state     <= wr_next;
      ca4l_awready <= awready_d;
      ca4l_wready  <= wready_d;
      ca4l_bvalid  <= bvalid_d;
      if (aw_hs) wr_idx <= ca4l_awaddr[AW-1:2];
      if (w_hs) begin
        wr_data <= ca4l_wdata;
        wr_strb <= ca4l_wstrb;
      end
      if (commit) ca4l_bresp <= wr_resp;
    end
  end

  // Control registers and their write pulses; a zero strobe still pulses dv.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) data_q[i] <= '0;
      dv_q <= '0;
    end else begin
      dv_q <= '0;
      if (commit && wr_is_ctrl) begin
        data_q[CW'(wr_idx)] <= ctrl_merged;
        dv_q[CW'(wr_idx)]   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ups_axi_regs.sv
// Directed self-checking bench for ups_axi_regs (NW=16, NS=4, AW=9).
module tb_ups_axi_regs;

  logic              clk;
  logic              rst;
  logic [32*16-1:0]  data;
  logic [15:0]       dv;
  logic [32*4-1:0]   status;
  logic [31:0]       araddr;
  logic              arvalid, arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid, rready;
  logic [31:0]       awaddr;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid, wready;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  int checks;
  int failures;

  ups_axi_regs #(.NW(16), .NS(4), .AW(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .data         (data),
    .dv           (dv),
    .status       (status),
    .ca4l_araddr  (araddr),
    .ca4l_arvalid (arvalid),
    .ca4l_arready (arready),
    .ca4l_rdata   (rdata),
    .ca4l_rresp   (rresp),
    .ca4l_rvalid  (rvalid),
    .ca4l_rready  (rready),
    .ca4l_awaddr  (awaddr),
    .ca4l_awvalid (awvalid),
    .ca4l_awready (awready),
    .ca4l_wdata   (wdata),
    .ca4l_wstrb   (wstrb),
    .ca4l_wvalid  (wvalid),
    .ca4l_wready  (wready),
    .ca4l_bresp   (bresp),
    .ca4l_bvalid  (bvalid),
    .ca4l_bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return data[32*i +: 32];
  endfunction

  // Full write with AW and W presented together; collects dv seen during it.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, output logic [1:0] resp,
                           output logic [15:0] dv_seen, output logic ok);
    int n;
    ok = 1'b1;
    dv_seen = '0;
    resp = 2'b11;
    awaddr = addr; wdata = wd; wstrb = st;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    dv_seen |= dv;
    n = 0;
    while (!bvalid && n < 20) begin tick(); dv_seen |= dv; n++; end
    if (!bvalid) ok = 1'b0;
    else resp = bresp;
    tick();
    dv_seen |= dv;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] rd,
                          output logic [1:0] resp, output logic ok);
    int n;
    ok = 1'b1;
    rd = 32'hx;
    resp = 2'b11;
    araddr = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) ok = 1'b0;
    else begin rd = rdata; resp = rresp; end
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [15:0] dvs;
    logic        ok;
    logic        seen;
    int          n;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    status = '0;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_arready", 32'(arready), 32'h0);
    chk("rst_awready", 32'(awready), 32'h0);
    chk("rst_wready",  32'(wready),  32'h0);
    chk("rst_rvalid",  32'(rvalid),  32'h0);
    chk("rst_bvalid",  32'(bvalid),  32'h0);
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_dv",      32'(dv),      32'h0);
    chk("rst_data2",   word(2),      32'h0);
    rst = 1'b0;
    tick();
    chk("idle_arready", 32'(arready), 32'h1);
    chk("idle_awready", 32'(awready), 32'h1);

    // Reset mid-write: preload idx 2, accept AW only, then reset
    axi_write(32'h08, 32'h55AA55AA, 4'hF, resp, dvs, ok);
    chk("pre_ok", 32'(ok), 32'h1);
    chk("pre_data2", word(2), 32'h55AA55AA);
    awaddr = 32'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= bvalid; end
    chk("midrst_no_bvalid", 32'(seen), 32'h0);
    chk("midrst_data2", word(2), 32'h0);
    axi_write(32'h08, 32'h12345678, 4'hF, resp, dvs, ok);
    chk("midrst_wr_ok", 32'(ok), 32'h1);
    chk("midrst_wr_bresp", 32'(resp), 32'h0);
    chk("midrst_wr_data2", word(2), 32'h12345678);
    chk("midrst_wr_dv", 32'(dvs), 32'h0004);

    // W before AW: W handshake at cycle 0, AW at cycle 3, bvalid at cycle 5
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    chk("wfirst_wready", 32'(wready), 32'h1);
    tick();                       // cycle 1
    wvalid = 1'b0;
    chk("wfirst_wready_drop", 32'(wready), 32'h0);
    chk("wfirst_no_bvalid", 32'(bvalid), 32'h0);
    tick();                       // cycle 2
    tick();                       // cycle 3
    awaddr = 32'h08; awvalid = 1'b1;
    chk("wfirst_awready", 32'(awready), 32'h1);
    tick();                       // cycle 4
    awvalid = 1'b0;
    chk("wfirst_c4_bvalid", 32'(bvalid), 32'h0);
    chk("wfirst_c4_dv", 32'(dv), 32'h0);
    tick();                       // cycle 5
    chk("wfirst_c5_bvalid", 32'(bvalid), 32'h1);
    chk("wfirst_c5_bresp", 32'(bresp), 32'h0);
    chk("wfirst_c5_dv", 32'(dv), 32'h0004);
    chk("wfirst_data2", word(2), 32'hDEADBEEF);
    tick();                       // cycle 6
    chk("wfirst_c6_dv", 32'(dv), 32'h0);
    chk("wfirst_c6_bvalid", 32'(bvalid), 32'h0);

    // Byte strobes
    axi_write(32'h00, 32'h11223344, 4'hF, resp, dvs, ok);
    chk("strb_pre", word(0), 32'h11223344);
    axi_write(32'h00, 32'hAABBCCDD, 4'b0101, resp, dvs, ok);
    chk("strb_bresp", 32'(resp), 32'h0);
    chk("strb_data0", word(0), 32'h11BB33DD);
    axi_read(32'h00, rd, resp, ok);
    chk("strb_rd_ok", 32'(ok), 32'h1);
    chk("strb_rdata", rd, 32'h11BB33DD);
    chk("strb_rresp", 32'(resp), 32'h0);
    axi_write(32'h00, 32'hFFFFFFFF, 4'b0000, resp, dvs, ok);
    chk("strb0_bresp", 32'(resp), 32'h0);
    chk("strb0_dv", 32'(dvs), 32'h0001);
    chk("strb0_data0", word(0), 32'h11BB33DD);

    // Last control register and upper address bits ignored
    axi_write(32'h3C, 32'h0F0F0F0F, 4'hF, resp, dvs, ok);
    chk("last_dv", 32'(dvs), 32'h8000);
    chk("last_data15", word(15), 32'h0F0F0F0F);
    axi_read(32'hF000_0E08, rd, resp, ok);
    chk("alias_rdata", rd, 32'hDEADBEEF);
    chk("alias_rresp", 32'(resp), 32'h0);

    // Unmapped read and write
    axi_read(32'h50, rd, resp, ok);
    chk("unmap_rdata", rd, 32'h0);
    chk("unmap_rresp", 32'(resp), 32'h2);
    axi_write(32'h54, 32'hCAFECAFE, 4'hF, resp, dvs, ok);
    chk("unmap_bresp", 32'(resp), 32'h2);
    chk("unmap_dv", 32'(dvs), 32'h0);
    chk("unmap_data0", word(0), 32'h11BB33DD);
    chk("unmap_data2", word(2), 32'hDEADBEEF);

    // Read backpressure
    rready = 1'b0;
    araddr = 32'h08; arvalid = 1'b1;
    tick();
    araddr = 32'h00;              // second request stays pending
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid",  32'(rvalid),  32'h1);
      chk("bp_rdata",   rdata,        32'hDEADBEEF);
      chk("bp_arready", 32'(arready), 32'h0);
      tick();
    end
    rready = 1'b1;
    tick();                       // R handshake
    chk("bp_after_rvalid",  32'(rvalid),  32'h0);
    chk("bp_after_arready", 32'(arready), 32'h1);
    tick();                       // pending AR 0x00 accepted
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("bp_next_rdata", rdata, 32'h11BB33DD);
    tick();

    // Same-register read decode coincident with write commit
    araddr = 32'h00; arvalid = 1'b1;
    awaddr = 32'h00; awvalid = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("coll_rvalid", 32'(rvalid), 32'h1);
    chk("coll_bvalid", 32'(bvalid), 32'h1);
    chk("coll_rdata",  rdata,       32'h11BB33DD);
    chk("coll_data0",  word(0),     32'hCAFEF00D);
    tick();

`ifdef UPS_AXI_REGS_W1C_EN
    // Sticky status with write-one-to-clear
    status[32*1 +: 32] = 32'h8;
    tick();
    status[32*1 +: 32] = 32'h0;
    tick();
    axi_read(32'h44, rd, resp, ok);
    chk("w1c_set", rd, 32'h8);
    axi_write(32'h44, 32'h8, 4'hF, resp, dvs, ok);
    chk("w1c_bresp", 32'(resp), 32'h0);
    chk("w1c_dv", 32'(dvs), 32'h0);
    axi_read(32'h44, rd, resp, ok);
    chk("w1c_clr", rd, 32'h0);
    status[32*1 +: 32] = 32'h8;
    axi_write(32'h44, 32'h8, 4'hF, resp, dvs, ok);
    status[32*1 +: 32] = 32'h0;
    axi_read(32'h44, rd, resp, ok);
    chk("w1c_set_wins", rd, 32'h8);
`else
    // Read-only registered status
    status[32*1 +: 32] = 32'h8;
    status[32*3 +: 32] = 32'hA5A50003;
    tick();
    axi_read(32'h44, rd, resp, ok);
    chk("stat1_rdata", rd, 32'h8);
    chk("stat1_rresp", 32'(resp), 32'h0);
    axi_read(32'h4C, rd, resp, ok);
    chk("stat3_rdata", rd, 32'hA5A50003);
    axi_write(32'h44, 32'h8, 4'hF, resp, dvs, ok);
    chk("stat_wr_bresp", 32'(resp), 32'h2);
    chk("stat_wr_dv", 32'(dvs), 32'h0);
    axi_read(32'h44, rd, resp, ok);
    chk("stat_wr_noeffect", rd, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
